scatter_fork_ctrl: RTL and testbench
====================================

Name: scatter_fork_ctrl

Overview:
- Sequences the two output streams of the scatter datapath (large-column stream, small-column stream) into the separate high- and low-precision compute paths.
- Takes one upstream beat, then forks it to two independently back-pressured downstream consumers.
- Counts beats per tile, tags the last beat of each tile, and pulses tile completion once both branches have drained.
- Branch enables are sampled per tile, so a tile with no large (or no small) columns skips that path entirely.

Parameters:
- IN_WIDTH, 16, element width in bits (FP16).
- IN_SIZE, 4, elements per row (columns).
- IN_PARALLELISM, 1, rows per beat; beat carries IN_SIZE*IN_PARALLELISM elements.
- TILE_BEATS, 4, beats per tile, must be >= 1.
- CNT_W, $clog2(TILE_BEATS)+1 (derived), beat counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_large_en  in  1  large branch enabled for the tile; sampled on the first accepted beat of the tile.
- cfg_small_en  in  1  small branch enabled; same sampling rule.
- data_in_large  in  IN_WIDTH x IN_SIZE*IN_PARALLELISM  large-column elements from scatter.
- data_in_small  in  IN_WIDTH x IN_SIZE*IN_PARALLELISM  small-column elements from scatter.
- data_in_valid  in  1  upstream beat valid.
- data_in_ready  out  1  beat accepted when valid && ready.
- large_out  out  IN_WIDTH x IN_SIZE*IN_PARALLELISM  registered large data.
- large_out_valid  out  1
- large_out_ready  in  1
- large_out_last  out  1  qualifies large_out_valid; final beat of the tile.
- small_out, small_out_valid, small_out_ready, small_out_last: same shape and meaning for the small branch.
- beat_idx  out  CNT_W  index of the next beat to be accepted within the tile.
- tile_done  out  1  single-cycle pulse when a tile is fully drained.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset, asynchronous:
  - All *_valid, *_last, tile_done and busy are 0; data_in_ready is 0 while rst is high.
  - beat_idx = 0, state = IDLE, data registers = 0, sampled enables = 0.
- States (in scatter_ctrl_pkg):
  - IDLE: no tile in progress.
  - STREAM: beats 1..TILE_BEATS-1 pending.
  - DRAIN: last beat accepted, waiting for the branches to empty.
- A branch is free when its valid is 0, or ready is 1, or the branch is disabled for the current tile.
- data_in_ready = !rst && state != DRAIN && large_free && small_free.
  - In IDLE, freedom is evaluated against the live cfg_* values.
- On accept:
  - Each enabled branch register loads its data, sets valid and sets last = (beat_idx == TILE_BEATS-1).
  - A disabled branch discards its data and its valid stays 0.
  - beat_idx increments and wraps to 0 after TILE_BEATS-1.
- Latency: accept at edge N gives out_valid high from edge N (visible the cycle after the handshake). Full throughput of 1 beat/cycle when both readies are held high.
- Each branch's valid holds until its own handshake; the two branches may drain in different cycles. No data reordering, no drops on enabled branches.
- Transitions:
  - IDLE -> STREAM on accept when TILE_BEATS > 1.
  - IDLE -> DRAIN on accept when TILE_BEATS == 1.
  - STREAM -> DRAIN on accept of the last beat.
  - DRAIN -> IDLE when neither enabled branch holds a valid beat; tile_done = 1 for exactly that one cycle.
- Both branches disabled: beats are still accepted and counted; DRAIN exits in the cycle after entry; tile_done fires one cycle after the last accept.
- cfg_* changes mid-tile are ignored until the next IDLE accept.
- In DRAIN, ready stays 0 even if both branches are free, so no overlap between tiles. Next-tile accept is possible earliest in the cycle tile_done is high (state is IDLE).
- Reset mid-tile discards all held beats, with no tile_done.
- The ready/valid rule holds for both branches: once out_valid is high, data and last stay stable until the handshake.

Decomposition:
- scatter_ctrl_pkg:
  - state_t enum (IDLE, STREAM, DRAIN).
  - Localparam helper for CNT_W.
- Sub-module fork_branch_reg:
  - Single-entry valid/ready register with data, last, enable and free output.
  - Instantiated twice (large, small).
- Top level holds the FSM, beat counter and enable sampling.

Test Plan:
- Streaming: TILE_BEATS=4, both enables 1, both readies 1, 4 back-to-back beats (large=0x3C00.., small=0x0001..) -> outputs one cycle after each accept; last only on beat 3; tile_done 1 cycle after the final handshake; beat_idx 0,1,2,3,0.
- Asymmetric stall: small_out_ready=0 for 3 cycles on beat 1 -> data_in_ready 0 for those cycles; large beat 1 handshakes at once, small beat 1 holds stable, no beat lost or duplicated.
- Branch skip: cfg_large_en=0, cfg_small_en=1 for tile 0, then 1/1 for tile 1 -> large_out_valid never rises in tile 0 and rises in tile 1; mid-tile cfg toggles have no effect.
- Both disabled: 4 beats accepted -> no out valid; tile_done exactly once, 1 cycle after the 4th accept.
- Drain blocking: after the last beat, large_out_ready=0 for 5 cycles while data_in_valid stays 1 -> state DRAIN, data_in_ready 0, tile_done on the cycle large drains; the next tile accepts that same cycle.
- Async reset: assert rst mid-tile (beat_idx=2) between clock edges -> valids, busy and data_in_ready drop immediately; after release beat_idx=0 and no tile_done.

Source files
------------

// File: rtl/scatter_ctrl_pkg.sv
// Shared types for the scatter fork controller: FSM state encoding and the
// beat-counter width helper.
package scatter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // Counter must hold 0..TILE_BEATS-1 with one bit of headroom.
  function automatic int cnt_width(input int beats);
    return $clog2(beats) + 1;
  endfunction

endpackage

// File: rtl/scatter_fork_ctrl_if.sv
// Upstream beat port plus the large and small downstream streams of the
// scatter fork controller.
interface scatter_fork_ctrl_if #(
  parameter int IN_WIDTH       = 16,
  parameter int IN_SIZE        = 4,
  parameter int IN_PARALLELISM = 1
);
  localparam int BEAT_W = IN_WIDTH * IN_SIZE * IN_PARALLELISM;

  // Handshake rule for every stream here: a beat transfers on a rising edge
  // where valid && ready; once valid is high, data and last hold until that
  // edge, and valid never depends combinationally on ready.
  logic [BEAT_W-1:0] data_in_large;
  logic [BEAT_W-1:0] data_in_small;
  logic              data_in_valid;
  logic              data_in_ready;

  logic [BEAT_W-1:0] large_out;
  logic              large_out_valid;
  logic              large_out_ready;
  logic              large_out_last;

  logic [BEAT_W-1:0] small_out;
  logic              small_out_valid;
  logic              small_out_ready;
  logic              small_out_last;

  modport master (
    output data_in_large, data_in_small, data_in_valid,
    output large_out_ready, small_out_ready,
    input  data_in_ready,
    input  large_out, large_out_valid, large_out_last,
    input  small_out, small_out_valid, small_out_last
  );

  modport slave (
    input  data_in_large, data_in_small, data_in_valid,
    input  large_out_ready, small_out_ready,
    output data_in_ready,
    output large_out, large_out_valid, large_out_last,
    output small_out, small_out_valid, small_out_last
  );

endinterface

// File: rtl/fork_branch_reg.sv
// Single-entry valid/ready holding register for one fork branch. A disabled
// branch never loads and always reports itself free.
module fork_branch_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] data_in,
  input  logic         last_in,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         last,
  output logic         free
);

  assign free = !valid || ready || !en;

  // A load in the same cycle as a drain replaces the beat, keeping valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load && en) begin
      data  <= data_in;
      valid <= 1'b1;
      last  <= last_in;
    end else if (valid && ready) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/scatter_fork_ctrl.sv
// Forks each upstream beat into the large and small compute paths, counts
// beats per tile, tags the last beat and pulses tile_done once both drain.
module scatter_fork_ctrl
  import scatter_ctrl_pkg::*;
#(
  parameter int IN_WIDTH       = 16,
  parameter int IN_SIZE        = 4,
  parameter int IN_PARALLELISM = 1,
  parameter int TILE_BEATS     = 4,
  localparam int CNT_W         = cnt_width(TILE_BEATS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_large_en,
  input  logic                cfg_small_en,
  scatter_fork_ctrl_if.slave  bus,
  output logic [CNT_W-1:0]    beat_idx,
  output logic                tile_done,
  output logic                busy,
  output state_t              fsm_state
);

  localparam int BEAT_W = IN_WIDTH * IN_SIZE * IN_PARALLELISM;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TILE_BEATS - 1);

  state_t state;
  logic   large_en_q;
  logic   small_en_q;
  logic   large_en;
  logic   small_en;
  logic   large_free;
  logic   small_free;
  logic   accept;
  logic   last_beat;

  // Before the first beat of a tile the sampled enables are stale, so the
  // live config decides which branches must be free.
  assign large_en = (state == IDLE) ? cfg_large_en : large_en_q;
  assign small_en = (state == IDLE) ? cfg_small_en : small_en_q;

  assign bus.data_in_ready = !rst && (state != DRAIN) && large_free && small_free;
  assign accept            = bus.data_in_valid && bus.data_in_ready;
  assign last_beat         = (beat_idx == LAST_IDX);

  assign busy      = (state != IDLE);
  assign fsm_state = state;

  fork_branch_reg #(.W(BEAT_W)) u_large (
    .clk     (clk),
    .rst     (rst),
    .en      (large_en),
    .load    (accept),
    .data_in (bus.data_in_large),
    .last_in (last_beat),
    .ready   (bus.large_out_ready),
    .data    (bus.large_out),
    .valid   (bus.large_out_valid),
    .last    (bus.large_out_last),
    .free    (large_free)
  );

  fork_branch_reg #(.W(BEAT_W)) u_small (
    .clk     (clk),
    .rst     (rst),
    .en      (small_en),
    .load    (accept),
    .data_in (bus.data_in_small),
    .last_in (last_beat),
    .ready   (bus.small_out_ready),
    .data    (bus.small_out),
    .valid   (bus.small_out_valid),
    .last    (bus.small_out_last),
    .free    (small_free)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beat_idx   <= '0;
      large_en_q <= 1'b0;
      small_en_q <= 1'b0;
      tile_done  <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      if (accept) begin
        beat_idx <= last_beat ? '0 : beat_idx + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (accept) begin
            large_en_q <= cfg_large_en;
            small_en_q <= cfg_small_en;
            state      <= last_beat ? DRAIN : STREAM;
          end
        end
        STREAM: begin
          if (accept && last_beat) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Exit only once the registered valids show both branches empty.
          if (!(large_en_q && bus.large_out_valid) &&
              !(small_en_q && bus.small_out_valid)) begin
            state     <= IDLE;
            tile_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scatter_fork_ctrl.sv
// Self-checking bench for scatter_fork_ctrl: per-branch expected queues fed
// by a reference model of beat counting and enable sampling.
module tb_scatter_fork_ctrl;
  import scatter_ctrl_pkg::*;

  localparam int BW = 64;
  localparam int W  = BW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         cfg_large_en;
  logic         cfg_small_en;
  logic [2:0]   beat_idx;
  logic         tile_done;
  logic         busy;
  state_t       fsm_state;

  scatter_fork_ctrl_if #(.IN_WIDTH(16), .IN_SIZE(4), .IN_PARALLELISM(1)) bus ();

  scatter_fork_ctrl #(
    .IN_WIDTH(16), .IN_SIZE(4), .IN_PARALLELISM(1), .TILE_BEATS(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_large_en (cfg_large_en),
    .cfg_small_en (cfg_small_en),
    .bus          (bus.slave),
    .beat_idx     (beat_idx),
    .tile_done    (tile_done),
    .busy         (busy),
    .fsm_state    (fsm_state)
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] exp_large_q[$];
  logic [W-1:0] exp_small_q[$];
  logic [W-1:0] exp_w;

  int   model_idx  = 0;
  logic model_en_l = 1'b0;
  logic model_en_s = 1'b0;
  int   accept_cnt = 0;
  int   done_cnt   = 0;
  logic large_seen = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] rep(input logic [15:0] e);
    return {e, e, e, e};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.large_out_valid) large_seen = 1'b1;
      if (bus.large_out_valid && bus.large_out_ready) begin
        if (exp_large_q.size() == 0) check("large_extra", 1, 0);
        else begin
          exp_w = exp_large_q.pop_front();
          check("large_beat", {bus.large_out_last, bus.large_out}, exp_w);
        end
      end
      if (bus.small_out_valid && bus.small_out_ready) begin
        if (exp_small_q.size() == 0) check("small_extra", 1, 0);
        else begin
          exp_w = exp_small_q.pop_front();
          check("small_beat", {bus.small_out_last, bus.small_out}, exp_w);
        end
      end
      if (tile_done) done_cnt++;
      if (bus.data_in_valid && bus.data_in_ready) begin
        check("beat_idx", beat_idx, model_idx);
        if (model_idx == 0) begin
          model_en_l = cfg_large_en;
          model_en_s = cfg_small_en;
        end
        if (model_en_l) exp_large_q.push_back({model_idx == 3, bus.data_in_large});
        if (model_en_s) exp_small_q.push_back({model_idx == 3, bus.data_in_small});
        model_idx = (model_idx == 3) ? 0 : model_idx + 1;
        accept_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called and returns 1ns after a rising edge; leaves data_in_valid high.
  task automatic send_beat(input logic [BW-1:0] dl, input logic [BW-1:0] ds);
    bit ok = 0;
    bus.data_in_large = dl;
    bus.data_in_small = ds;
    bus.data_in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ok = bus.data_in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic wait_done(input string tag, input int exp_k);
    bit found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tile_done) begin
        check(tag, k, exp_k);
        found = 1;
        break;
      end
    end
    if (!found) check({tag, "_timeout"}, 0, 1);
    @(negedge clk);
    check({tag, "_pulse"}, tile_done, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_tile(input logic [15:0] lb, input logic [15:0] sb);
    for (int i = 0; i < 4; i++) send_beat(rep(lb + 16'(i)), rep(sb + 16'(i)));
    bus.data_in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [BW-1:0] hold_small;
  int            acc0;
  bit            found5;

  initial begin
    rst = 1'b1;
    cfg_large_en = 1'b1;
    cfg_small_en = 1'b1;
    bus.data_in_large = '0;
    bus.data_in_small = '0;
    bus.data_in_valid = 1'b0;
    bus.large_out_ready = 1'b1;
    bus.small_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", bus.data_in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_lvalid", bus.large_out_valid, 0);
    check("rst_svalid", bus.small_out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_idx", beat_idx, 0);
    check("rst_done", tile_done, 0);
    check("rst_state", fsm_state, IDLE);
    check("rst_ldata", bus.large_out, 0);
    @(posedge clk);
    #1;

    // Streaming, both branches, back-to-back.
    send_beat(rep(16'h3C00), rep(16'h0001));
    check("t1_lat_lvalid", bus.large_out_valid, 1);
    check("t1_lat_ldata", bus.large_out, rep(16'h3C00));
    check("t1_lat_sdata", bus.small_out, rep(16'h0001));
    check("t1_busy", busy, 1);
    for (int i = 1; i < 4; i++) send_beat(rep(16'h3C00 + 16'(i)), rep(16'h0001 + 16'(i)));
    bus.data_in_valid = 1'b0;
    wait_done("t1_done_lat", 2);
    check("t1_idx_wrap", beat_idx, 0);

    // Asymmetric stall on beat 1 of the small branch.
    send_beat(rep(16'h1000), rep(16'h2000));
    send_beat(rep(16'h1001), rep(16'h2001));
    bus.small_out_ready = 1'b0;
    bus.data_in_valid = 1'b0;
    hold_small = bus.small_out;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_in_ready", bus.data_in_ready, 0);
      check("t2_s_hold", {bus.small_out_valid, bus.small_out_last, bus.small_out},
            {2'b10, hold_small});
      @(posedge clk);
      #1;
    end
    check("t2_l_drained", bus.large_out_valid, 0);
    bus.small_out_ready = 1'b1;
    send_beat(rep(16'h1002), rep(16'h2002));
    send_beat(rep(16'h1003), rep(16'h2003));
    bus.data_in_valid = 1'b0;
    wait_done("t2_done_lat", 2);

    // Branch skip with mid-tile cfg toggles.
    cfg_large_en = 1'b0;
    cfg_small_en = 1'b1;
    large_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_beat(rep(16'($urandom_range(0, 65535))), rep(16'($urandom_range(0, 65535))));
      cfg_large_en = ~cfg_large_en;
      cfg_small_en = ~cfg_small_en;
    end
    bus.data_in_valid = 1'b0;
    wait_done("t3a_done_lat", 2);
    check("t3a_no_large", large_seen, 0);
    cfg_large_en = 1'b1;
    cfg_small_en = 1'b1;
    large_seen = 1'b0;
    send_tile(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
    wait_done("t3b_done_lat", 2);
    check("t3b_large", large_seen, 1);

    // Both branches disabled.
    cfg_large_en = 1'b0;
    cfg_small_en = 1'b0;
    large_seen = 1'b0;
    acc0 = accept_cnt;
    send_tile(16'h5000, 16'h6000);
    check("t4_accepts", accept_cnt, acc0 + 4);
    wait_done("t4_done_lat", 1);
    check("t4_no_large", large_seen, 0);

    // Drain blocking with upstream still valid.
    cfg_large_en = 1'b1;
    cfg_small_en = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(rep(16'h7000 + 16'(i)), rep(16'h7100 + 16'(i)));
    bus.large_out_ready = 1'b0;
    bus.data_in_large = rep(16'h8000);
    bus.data_in_small = rep(16'h8100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_state", fsm_state, DRAIN);
      check("t5_in_ready", bus.data_in_ready, 0);
      check("t5_no_done", tile_done, 0);
      @(posedge clk);
      #1;
    end
    bus.large_out_ready = 1'b1;
    acc0 = accept_cnt;
    found5 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tile_done) begin
        check("t5_done_lat", k, 2);
        check("t5_ready_on_done", bus.data_in_ready, 1);
        check("t5_idle_on_done", fsm_state, IDLE);
        found5 = 1;
        break;
      end
    end
    if (!found5) check("t5_done_timeout", 0, 1);
    @(posedge clk);
    #1;
    check("t5_next_accept", accept_cnt, acc0 + 1);
    for (int i = 1; i < 4; i++) send_beat(rep(16'h8000 + 16'(i)), rep(16'h8100 + 16'(i)));
    bus.data_in_valid = 1'b0;
    wait_done("t5b_done_lat", 2);

    // Asynchronous reset mid-tile.
    send_beat(rep(16'h9000), rep(16'h9100));
    send_beat(rep(16'h9001), rep(16'h9101));
    bus.data_in_valid = 1'b0;
    bus.large_out_ready = 1'b0;
    bus.small_out_ready = 1'b0;
    @(negedge clk);
    check("t6_idx_pre", beat_idx, 2);
    #2;
    rst = 1'b1;
    exp_large_q.delete();
    exp_small_q.delete();
    model_idx = 0;
    #1;
    check("t6_lvalid", bus.large_out_valid, 0);
    check("t6_svalid", bus.small_out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_in_ready", bus.data_in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.large_out_ready = 1'b1;
    bus.small_out_ready = 1'b1;
    acc0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_idx_post", beat_idx, 0);
      check("t6_no_done", tile_done, 0);
    end
    check("t6_done_cnt", done_cnt, acc0);
    @(posedge clk);
    #1;
    send_tile(16'hA000, 16'hA100);
    wait_done("t6b_done_lat", 2);

    // Final report.
    repeat (2) @(negedge clk);
    check("end_large_q", exp_large_q.size(), 0);
    check("end_small_q", exp_small_q.size(), 0);
    check("end_tiles", done_cnt, 8);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
